// File: rtl/spi_master_multi_if.sv
// Host and SPI-pin signal bundle for spi_master_multi.
// Host handshake: start is sampled only while busy is low; busy rises the cycle after acceptance and done pulses for one cycle when it falls.
interface spi_master_multi_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 3
);
  localparam int SEL_W = $clog2(NUM_SLAVES) + 1;

  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [SEL_W-1:0]      slave_sel;
  logic                  cpol;
  logic                  cpha;
  logic                  lsb_first;
  logic                  miso;
  logic                  sclk;
  logic                  mosi;
  logic [NUM_SLAVES-1:0] cs_n;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_WIDTH-1:0] rx_data;

  modport master (
    input  start, tx_data, slave_sel, cpol, cpha, lsb_first, miso,
    output sclk, mosi, cs_n, busy, done, err, rx_data
  );

  modport slave (
    output start, tx_data, slave_sel, cpol, cpha, lsb_first, miso,
    input  sclk, mosi, cs_n, busy, done, err, rx_data
  );
endinterface

// File: rtl/spi_master_multi.sv
// Full-duplex SPI master: all CPOL/CPHA modes, MSB/LSB first, NUM_SLAVES chip selects.
// Every SCLK edge lands on a divider tick; the toggle count tells leading from trailing edges.
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 3,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_master_multi_if.master    bus,
  output logic [1:0]            dbg_state
);
  localparam int W     = DATA_WIDTH;
  localparam int SEL_W = $clog2(NUM_SLAVES) + 1;
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int TOG_W = $clog2(2 * DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [TOG_W-1:0]      tog_cnt_q, tog_cnt_d;
  logic [W-1:0]          tx_sh_q, tx_sh_d;
  logic [W-1:0]          rx_sh_q, rx_sh_d;
  logic [W-1:0]          rx_data_q, rx_data_d;
  logic [NUM_SLAVES-1:0] cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  tick;
  logic [TOG_W-1:0]      k;
  logic                  sample_edge;

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    tick        = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    k           = tog_cnt_q + TOG_W'(1);
    // Odd k is a leading edge; cpha=0 samples there, cpha=1 samples on trailing edges.
    sample_edge = k[0] ^ cpha_q;

    unique case (state_q)
      S_IDLE: begin
        sclk_d    = bus.cpol;
        div_cnt_d = '0;
        tog_cnt_d = '0;
        if (bus.start) begin
          if (bus.slave_sel >= SEL_W'(NUM_SLAVES)) begin
            err_d = 1'b1;
          end else begin
            state_d = S_SETUP;
            busy_d  = 1'b1;
            cs_n_d  = ~(NUM_SLAVES'(1) << bus.slave_sel);
            tx_sh_d = bus.tx_data;
            rx_sh_d = '0;
            cpha_d  = bus.cpha;
            lsb_d   = bus.lsb_first;
            if (!bus.cpha) mosi_d = bus.lsb_first ? bus.tx_data[0] : bus.tx_data[W-1];
          end
        end
      end
      S_SETUP, S_XFER: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        if (tick) begin
          sclk_d    = ~sclk_q;
          tog_cnt_d = k;
          state_d   = (k == TOG_W'(2 * W)) ? S_HOLD : S_XFER;
          if (sample_edge) begin
            rx_sh_d = lsb_q ? {bus.miso, rx_sh_q[W-1:1]} : {rx_sh_q[W-2:0], bus.miso};
          end else if (cpha_q && (k == TOG_W'(1))) begin
            mosi_d = lsb_q ? tx_sh_q[0] : tx_sh_q[W-1];
          end else if (k != TOG_W'(2 * W)) begin
            tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
            mosi_d  = lsb_q ? tx_sh_q[1] : tx_sh_q[W-2];
          end
        end
      end
      S_HOLD: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        if (tick) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cs_n_d    = '1;
          rx_data_d = rx_sh_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      tog_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cs_n_q    <= '1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      tog_cnt_q <= tog_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.rx_data = rx_data_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi: a negedge monitor models the slave and checks each done.
// Expectations are queued when a transfer is started and popped when done pulses.
module tb_spi_master_multi;
  localparam int W     = 8;
  localparam int NS    = 3;
  localparam int D     = 2;
  localparam int SEL_W = $clog2(NS) + 1;

  typedef struct {
    logic [W-1:0]  mosi;
    logic [NS-1:0] cs_n;
    logic          cpol;
    int            t0;
  } meta_t;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  spi_master_multi_if #(.DATA_WIDTH(W), .NUM_SLAVES(NS)) bus ();

  spi_master_multi #(.DATA_WIDTH(W), .NUM_SLAVES(NS), .CLK_DIV(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  meta_t        meta_q[$];
  meta_t        mon_m;
  int           n_checks = 0;
  int           n_errors = 0;
  int           tog = 0;
  int           idx;
  int           last_t0 = 0;
  int           done_cnt = 0;
  logic [W-1:0] mosi_cap = '0;
  logic         sclk_prev = 1'b0;
  logic         cur_cpha = 1'b0;
  logic         cur_lsb = 1'b0;
  logic         loopback = 1'b0;
  logic [W-1:0] slave_word = '0;
  logic         slave_bit;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Slave model: drives its word in the master's bit order, advancing on its shift edges.
  always @* begin
    idx = cur_cpha ? ((tog == 0) ? 0 : (tog - 1) / 2) : tog / 2;
    if (idx >= W) slave_bit = 1'b0;
    else          slave_bit = cur_lsb ? slave_word[idx] : slave_word[W-1-idx];
  end
  assign bus.miso = loopback ? bus.mosi : slave_bit;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        mon_m = meta_q.pop_front();
        check_eq("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
        check_eq("done_latency", 32'(cyc - mon_m.t0), 32'((2 * W + 1) * D + 1));
        check_eq("sclk_toggles", 32'(tog), 32'(2 * W));
        check_eq("mosi_bits", 32'(mosi_cap), 32'(mon_m.mosi));
        check_eq("sclk_idle", 32'(bus.sclk), 32'(mon_m.cpol));
        check_eq("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
    if (meta_q.size() != 0 && cyc == meta_q[0].t0 + 1) begin
      check_eq("busy_after_start", 32'(bus.busy), 32'd1);
      check_eq("cs_n_active", 32'(bus.cs_n), 32'(meta_q[0].cs_n));
    end
    if (&bus.cs_n) begin
      tog      = 0;
      mosi_cap = '0;
    end else if (bus.sclk !== sclk_prev) begin
      tog++;
      if (tog[0] ^ cur_cpha) mosi_cap = {mosi_cap[W-2:0], bus.mosi};
    end
    sclk_prev = bus.sclk;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] tx, input logic [SEL_W-1:0] sel, input logic [1:0] mode,
                      input logic lsb, input logic lb, input logic [W-1:0] sw, input logic early);
    meta_t m;
    bus.cpol      = mode[1];
    bus.cpha      = mode[0];
    bus.lsb_first = lsb;
    // Let the idle sclk settle at the new cpol before cs_n drops.
    if (early) @(negedge clk);
    cur_cpha      = mode[0];
    cur_lsb       = lsb;
    loopback      = lb;
    slave_word    = sw;
    bus.tx_data   = tx;
    bus.slave_sel = sel;
    bus.start     = 1'b1;
    for (int i = 0; i < NS; i++) m.cs_n[i] = (i != int'(sel));
    m.mosi  = lsb ? rev(tx) : tx;
    m.cpol  = mode[1];
    m.t0    = cyc;
    last_t0 = cyc;
    exp_q.push_back(lb ? tx : sw);
    meta_q.push_back(m);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.tx_data = $urandom_range(0, 255);
    bus.cpha    = $urandom_range(0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check_eq("xfer_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    meta_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones_before;
    logic [1:0] mode;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.tx_data   = '0;
    bus.slave_sel = '0;
    bus.cpol      = 1'b1;
    bus.cpha      = 1'b0;
    bus.lsb_first = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sclk", 32'(bus.sclk), 32'd0);
    check_eq("rst_mosi", 32'(bus.mosi), 32'd0);
    check_eq("rst_cs_n", 32'(bus.cs_n), 32'h7);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // All four modes, miso held low, slave 0.
    for (int m = 0; m < 4; m++) begin
      send(8'hFF, 0, 2'(m), 1'b0, 1'b0, 8'h00, 1'b1);
      wait_idle();
    end

    // Loopback in every mode, both bit orders.
    for (int l = 0; l < 2; l++) begin
      for (int m = 0; m < 4; m++) begin
        send(8'hA5, SEL_W'($urandom_range(0, NS - 1)), 2'(m), 1'(l), 1'b1, 8'h00, 1'b1);
        wait_idle();
      end
    end

    // Slave 2 returns 0x3C in mode 1 while the master sends 0xA5.
    send(8'hA5, 2, 2'd1, 1'b0, 1'b0, 8'h3C, 1'b1);
    wait_idle();

    // Random transfers.
    for (int r = 0; r < 6; r++) begin
      send(W'($urandom_range(0, 255)), SEL_W'($urandom_range(0, NS - 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), 1'b1);
      wait_idle();
    end

    // Out-of-range slave select.
    bus.slave_sel = 3;
    bus.tx_data   = 8'h5A;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("err_pulse", 32'(bus.err), 32'd1);
    check_eq("err_cs_n", 32'(bus.cs_n), 32'h7);
    check_eq("err_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check_eq("err_one_cycle", 32'(bus.err), 32'd0);
    check_eq("err_stays_idle", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);

    // Reset asserted on the edge of the 5th sclk toggle, mode 2.
    send(8'hC3, 1, 2'd2, 1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (cyc >= last_t0 + 5 * D) break;
      @(negedge clk);
    end
    dones_before = done_cnt;
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    meta_q.delete();
    check_eq("abort_cs_n", 32'(bus.cs_n), 32'h7);
    check_eq("abort_sclk", 32'(bus.sclk), 32'd0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt), 32'(dones_before));

    // Back-to-back: second start issued in the done cycle of the first.
    mode = 2'($urandom_range(0, 3));
    send(8'h96, 0, mode, 1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check_eq("b2b_first_done", 32'(bus.done), 32'd1);
    send(8'h4E, 2, mode, 1'b1, 1'b0, 8'hD2, 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
